bankgroup_cmd_ctrl: RTL

Command front-end that sits directly upstream of the bank-group array and drives its per-bank bundles (rd_o_wr, dqin, row, column) while collecting dqout. Accepts one DRAM-style command per handshake (ACT/RD/WR/PRE/PREA), tracks open-row state per bank, enforces a fixed tRCD, and sequences BL-beat read/write bursts with column wrap inside the burst-aligned block.

---
 rtl/bankgroup_cmd_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bankgroup_cmd_ctrl.sv
// rtl/bankgroup_cmd_ctrl.sv - command front-end for the bank-group array
// Tracks per-bank open rows, enforces tRCD and runs wrapped BL-beat read/write bursts.
module bankgroup_cmd_ctrl #(
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int TRCD         = 2,
  localparam int BANKS       = 2**BAWIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [2:0]                     cmd_op,
  input  logic [BAWIDTH-1:0]             cmd_ba,
  input  logic [CHWIDTH-1:0]             cmd_row,
  input  logic [COLWIDTH-1:0]            cmd_col,
  input  logic [DEVICE_WIDTH-1:0]        wdata,
  output logic                           wdata_ready,
  output logic [DEVICE_WIDTH-1:0]        rdata,
  output logic                           rdata_valid,
  output logic                           cmd_err,
  output logic [BANKS-1:0]               rd_o_wr,
  output logic [BANKS*DEVICE_WIDTH-1:0]  dqin,
  input  logic [BANKS*DEVICE_WIDTH-1:0]  dqout,
  output logic [BANKS*CHWIDTH-1:0]       row,
  output logic [BANKS*COLWIDTH-1:0]      column
);

  localparam int BLW  = $clog2(BL);
  localparam int CNTW = $clog2(TRCD + 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;

  localparam logic [BLW-1:0]  BEAT_ONE  = BLW'(1);
  localparam logic [BLW-1:0]  BEAT_LAST = BLW'(BL - 1);
  localparam logic [CNTW-1:0] TRCD_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] TRCD_LOAD = CNTW'(TRCD - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_ACTIVATING,
    B_ACTIVE
  } bank_state_t;

  bank_state_t          state_q [BANKS];
  bank_state_t          state_d [BANKS];
  logic [CNTW-1:0]      trcd_q  [BANKS];
  logic [CNTW-1:0]      trcd_d  [BANKS];
  logic [CHWIDTH-1:0]   open_row_q [BANKS];
  logic [COLWIDTH-1:0]  col_q   [BANKS];

  logic                 busy_q;
  logic                 wr_q;
  logic [BAWIDTH-1:0]   bank_q;
  logic [BLW-1:0]       beat_q;

  logic                 cmd_fire;
  logic                 cmd_bad;
  logic                 start_burst;
  logic                 act_ok;
  logic [DEVICE_WIDTH-1:0] dq_sel;

  assign cmd_ready   = !busy_q;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign wdata_ready = busy_q && wr_q;

  always_comb begin
    cmd_bad     = 1'b0;
    start_burst = 1'b0;
    act_ok      = 1'b0;
    if (cmd_fire) begin
      case (cmd_op)
        OP_NOP, OP_PRE, OP_PREA: ;
        OP_ACT: begin
          if (state_q[cmd_ba] == B_IDLE) act_ok = 1'b1;
          else                           cmd_bad = 1'b1;
        end
        OP_RD, OP_WR: begin
          if (state_q[cmd_ba] == B_ACTIVE) start_burst = 1'b1;
          else                             cmd_bad = 1'b1;
        end
        default: cmd_bad = 1'b1;
      endcase
    end
  end

  // TRCD==1 lets an ACT go straight to ACTIVE so RD/WR is legal on the next edge.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      state_d[b] = state_q[b];
      trcd_d[b]  = trcd_q[b];
      if (state_q[b] == B_ACTIVATING) begin
        if (trcd_q[b] <= TRCD_ONE) state_d[b] = B_ACTIVE;
        else                       trcd_d[b]  = trcd_q[b] - TRCD_ONE;
      end
      if (cmd_fire) begin
        if (cmd_op == OP_PREA || (cmd_op == OP_PRE && cmd_ba == BAWIDTH'(b))) begin
          state_d[b] = B_IDLE;
        end else if (act_ok && cmd_ba == BAWIDTH'(b)) begin
          state_d[b] = (TRCD <= 1) ? B_ACTIVE : B_ACTIVATING;
          trcd_d[b]  = TRCD_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= B_IDLE;
        trcd_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        state_q[b] <= state_d[b];
        trcd_q[b]  <= trcd_d[b];
      end
    end
  end

  always_comb begin
    dq_sel = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_q == BAWIDTH'(b)) dq_sel = dqout[b*DEVICE_WIDTH +: DEVICE_WIDTH];
    end
  end

  // Only the low log2(BL) column bits advance, so the burst wraps inside its aligned block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      wr_q        <= 1'b0;
      bank_q      <= '0;
      beat_q      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      cmd_err     <= 1'b0;
      for (int b = 0; b < BANKS; b++) begin
        open_row_q[b] <= '0;
        col_q[b]      <= '0;
      end
    end else begin
      cmd_err     <= cmd_bad;
      rdata_valid <= busy_q && !wr_q;
      if (busy_q && !wr_q) rdata <= dq_sel;
      if (act_ok) open_row_q[cmd_ba] <= cmd_row;
      if (start_burst) begin
        busy_q         <= 1'b1;
        wr_q           <= (cmd_op == OP_WR);
        bank_q         <= cmd_ba;
        beat_q         <= '0;
        col_q[cmd_ba]  <= cmd_col;
      end else if (busy_q) begin
        if (beat_q == BEAT_LAST) begin
          busy_q <= 1'b0;
        end else begin
          beat_q                  <= beat_q + BEAT_ONE;
          col_q[bank_q][BLW-1:0]  <= col_q[bank_q][BLW-1:0] + BEAT_ONE;
        end
      end
    end
  end

  always_comb begin
    rd_o_wr = '0;
    dqin    = '0;
    row     = '0;
    column  = '0;
    for (int b = 0; b < BANKS; b++) begin
      row[b*CHWIDTH +: CHWIDTH]     = open_row_q[b];
      column[b*COLWIDTH +: COLWIDTH] = col_q[b];
      if (busy_q && wr_q && bank_q == BAWIDTH'(b)) begin
        rd_o_wr[b]                             = 1'b1;
        dqin[b*DEVICE_WIDTH +: DEVICE_WIDTH]   = wdata;
      end
    end
  end

endmodule
